// File: rtl/write_reg.sv
// Posted-write front end of a 16x4 register file: queued writes, in-order commit FSM, flush/zero on clear.
// Optional WRITE_BYPASS_EN lets the read ports see queued writes (newest match) ahead of commit.
module write_reg #(
  parameter int DW    = 4,
  parameter int AW    = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [AW-1:0]            wa,
  input  logic [DW-1:0]            wd,
  input  logic                     clr_req,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [AW-1:0]            ra,
  input  logic [AW-1:0]            rb,
  output logic [DW-1:0]            busa,
  output logic [DW-1:0]            busb
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << AW;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [AW-1:0] r_idx;
  logic [DW-1:0] r_file [NREG];
  logic [AW-1:0] r_q_wa [DEPTH];
  logic [DW-1:0] r_q_wd [DEPTH];
  logic [DW-1:0] r_busa;
  logic [DW-1:0] r_busb;

  logic          w_push;
  logic [DW-1:0] w_view_a;
  logic [DW-1:0] w_view_b;

  assign wready = (r_count < C_FULL) && (r_state != S_CLEAR) && !clr_req && rst;
  assign w_push = wvalid && wready;
  assign busy   = (r_state != S_IDLE) || (r_count != '0);
  assign count  = r_count;
  assign busa   = r_busa;
  assign busb   = r_busb;

  // Queue storage needs no reset: only slots inside [rptr, rptr+count) are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_wa[r_wptr] <= wa;
      r_q_wd[r_wptr] <= wd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_idx   <= '0;
      for (int i = 0; i < NREG; i++) begin
        r_file[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (clr_req) begin
            r_idx   <= '0;
            r_state <= S_CLEAR;
          end else if (w_push) begin
            r_count <= r_count + 1'b1;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // wready is low under clr_req, so no push can race the flush.
          if (clr_req) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_idx   <= '0;
            r_state <= S_CLEAR;
          end else begin
            r_file[r_q_wa[r_rptr]] <= r_q_wd[r_rptr];
            r_rptr <= r_rptr + 1'b1;
            if (!w_push) begin
              r_count <= r_count - 1'b1;
              if (r_count == C_ONE) begin
                r_state <= S_IDLE;
              end
            end
          end
        end
        S_CLEAR: begin
          r_file[r_idx] <= '0;
          r_idx         <= r_idx + 1'b1;
          if (&r_idx) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef WRITE_BYPASS_EN
  logic [PW-1:0] w_slot;

  // Scan oldest to newest so the most recent matching queued write wins.
  always_comb begin
    w_view_a = r_file[ra];
    w_view_b = r_file[rb];
    w_slot   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_slot = r_rptr + PW'(i);
      if (CW'(i) < r_count) begin
        if (r_q_wa[w_slot] == ra) w_view_a = r_q_wd[w_slot];
        if (r_q_wa[w_slot] == rb) w_view_b = r_q_wd[w_slot];
      end
    end
  end
`else
  assign w_view_a = r_file[ra];
  assign w_view_b = r_file[rb];
`endif

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      r_busa <= '0;
      r_busb <= '0;
    end else begin
      r_busa <= w_view_a;
      r_busb <= w_view_b;
    end
  end

endmodule

// File: tb/tb_write_reg.sv
// Directed + random bench for write_reg, checked against a queue/array reference model.
module tb_write_reg;

  logic       clk;
  logic       rst;
  logic       wvalid;
  logic       wready;
  logic [3:0] wa;
  logic [3:0] wd;
  logic       clr_req;
  logic       busy;
  logic [2:0] count;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] busa;
  logic [3:0] busb;

  int n_tests = 0;
  int n_fail  = 0;

  write_reg dut (
    .clk(clk), .rst(rst), .wvalid(wvalid), .wready(wready), .wa(wa), .wd(wd),
    .clr_req(clr_req), .busy(busy), .count(count), .ra(ra), .rb(rb),
    .busa(busa), .busb(busb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] d;
  } ent_t;

  ent_t       m_q[$];
  logic [3:0] m_file [16];
  int         m_clr;

  function automatic logic [3:0] m_view(logic [3:0] x);
    logic [3:0] v;
    v = m_file[x];
`ifdef WRITE_BYPASS_EN
    foreach (m_q[i]) if (m_q[i].a == x) v = m_q[i].d;
`endif
    return v;
  endfunction

  function automatic logic m_ready();
    return (m_q.size() < 4) && (m_clr == 0) && !clr_req && rst;
  endfunction

  task automatic m_reset();
    m_q.delete();
    m_clr = 0;
    foreach (m_file[i]) m_file[i] = 4'h0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check wready pre-edge, advance model at posedge, check outputs after negedge.
  task automatic step();
    logic push;
    ent_t e;
    #1;
    chk("wready", wready, m_ready());
    push = wvalid && m_ready();
    e.a = wa;
    e.d = wd;
    @(posedge clk);
    if (m_clr > 0) begin
      m_file[16 - m_clr] = 4'h0;
      m_clr--;
    end else if (clr_req) begin
      m_q.delete();
      m_clr = 16;
    end else if (m_q.size() > 0) begin
      m_file[m_q[0].a] = m_q[0].d;
      void'(m_q.pop_front());
    end
    if (push) m_q.push_back(e);
    @(negedge clk);
    #1;
    chk("count", count, m_q.size());
    chk("count_le_depth", count <= 3'd4, 1'b1);
    chk("busy", busy, (m_clr > 0) || (m_q.size() > 0));
    chk("busa", busa, m_view(ra));
    chk("busb", busb, m_view(rb));
  endtask

  initial begin
    rst = 1'b1; wvalid = 1'b0; wa = '0; wd = '0; clr_req = 1'b0; ra = '0; rb = '0;
    m_reset();
    #3 rst = 1'b0;

    // 1: reset with clock running
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busa", busa, 4'h0);
    chk("rst_busb", busb, 4'h0);
    chk("rst_count", count, 3'd0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b1;
    #1;
    chk("rel_wready", wready, 1'b1);

    // 2: single write to address 5
    wvalid = 1'b1; wa = 4'd5; wd = 4'hA; ra = 4'd5; rb = 4'd0;
    step();
    wvalid = 1'b0;
    step();
    chk("t2_busa", busa, 4'hA);
    chk("t2_busy", busy, 1'b0);

    // 3: back-to-back writes to 1..6
    for (int i = 1; i <= 6; i++) begin
      wvalid = 1'b1; wa = 4'(i); wd = 4'($urandom_range(0, 15)); ra = 4'(i - 1); rb = 4'(i);
      step();
    end
    wvalid = 1'b0;
    repeat (2) step();
    for (int i = 1; i <= 6; i++) begin
      ra = 4'(i); rb = 4'(7 - i);
      step();
    end

    // 4: two writes to address 9, last one wins
    wvalid = 1'b1; wa = 4'd9; wd = 4'h3; rb = 4'd9; ra = 4'd9;
    step();
    wd = 4'hC;
    step();
    wvalid = 1'b0;
    repeat (2) step();
    chk("t4_busb", busb, 4'hC);

    // 5: clear during drain; pushes and repeat clears ignored while clearing
    wvalid = 1'b1; wa = 4'd2; wd = 4'h7;
    step();
    wa = 4'd3; wd = 4'h8;
    step();
    wvalid = 1'b0; clr_req = 1'b1;
    step();
    chk("t5_count", count, 3'd0);
    clr_req = 1'b0; wvalid = 1'b1; wa = 4'd4; wd = 4'hF;
    for (int i = 0; i < 16; i++) begin
      clr_req = (i == 5);
      ra = 4'(i); rb = 4'(15 - i);
      step();
    end
    clr_req = 1'b0; wvalid = 1'b0;
    chk("t5_busy_end", busy, 1'b0);
    for (int i = 0; i < 16; i++) begin
      ra = 4'(i); rb = 4'(15 - i);
      step();
    end

    // 6: reset in the middle of a clear
    wvalid = 1'b1; wa = 4'd11; wd = 4'h6; ra = 4'd11; rb = 4'd11;
    step();
    wvalid = 1'b0;
    repeat (2) step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (5) step();
    rst = 1'b0;
    #1;
    m_reset();
    chk("t6_count", count, 3'd0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_wready", wready, 1'b0);
    chk("t6_busa", busa, 4'h0);
    chk("t6_busb", busb, 4'h0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t6_rel_busy", busy, 1'b0);
    ra = 4'd5; rb = 4'd9;
    step();
    chk("t6_rel_busa", busa, 4'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      wvalid  = 1'($urandom_range(0, 1));
      wa      = 4'($urandom_range(0, 15));
      wd      = 4'($urandom_range(0, 15));
      ra      = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      rb      = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
      clr_req = ($urandom_range(0, 39) == 0);
      step();
    end
    clr_req = 1'b0; wvalid = 1'b0;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
